// File: rtl/binary_to_gray.sv
// Registered binary-to-Gray converter with a one-cycle latency and a valid qualifier.
// Optional BIN2GRAY_SELFCHECK_EN adds a decode-and-compare monitor with a sticky check_err.
module binary_to_gray #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] binary,
  output logic             out_valid,
  output logic [WIDTH-1:0] gray
`ifdef BIN2GRAY_SELFCHECK_EN
  ,
  output logic             check_err
`endif
);

  logic [WIDTH-1:0] gray_next;

  assign gray_next = binary ^ (binary >> 1);

  // gray only loads on accepted words, so binary is never sampled while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) gray <= gray_next;
    end
  end

`ifdef BIN2GRAY_SELFCHECK_EN
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] decoded;

  // each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    decoded = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      decoded[i] = ^(gray >> i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q     <= '0;
      check_err <= 1'b0;
    end else begin
      if (in_valid) bin_q <= binary;
      if (out_valid && (decoded != bin_q)) check_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_binary_to_gray.sv
// Self-checking bench for binary_to_gray: directed cases plus randomized traffic
// against a reflected-code lookup table built independently of the XOR rule.
module tb_binary_to_gray;

  localparam int unsigned W = 4;
  localparam int unsigned N = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] binary = '0;
  logic         out_valid;
  logic [W-1:0] gray;
`ifdef BIN2GRAY_SELFCHECK_EN
  logic         check_err;
`endif

  binary_to_gray #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .binary    (binary),
    .out_valid (out_valid),
    .gray      (gray)
`ifdef BIN2GRAY_SELFCHECK_EN
    ,
    .check_err (check_err)
`endif
  );

  always #5 clk = ~clk;

  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  logic [W-1:0] codes [N];
  logic [W-1:0] exp_gray = '0;
  logic         exp_valid = 1'b0;
  logic [W-1:0] prev_gray;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // drive at negedge, model the edge, sample 1 time unit after posedge
  task automatic step(input logic v, input logic [W-1:0] b, input string tag);
    @(negedge clk);
    in_valid = v;
    binary   = b;
    @(posedge clk);
    #1;
    exp_valid = v;
    if (v) exp_gray = codes[b];
    check({tag, ".valid"}, {31'b0, out_valid}, {31'b0, exp_valid});
    check({tag, ".gray"}, {{(32-W){1'b0}}, gray}, {{(32-W){1'b0}}, exp_gray});
  endtask

  initial begin
    // reflected Gray code: mirror the existing list and set the new top bit
    codes[0] = '0;
    for (int k = 0; k < W; k++) begin
      for (int j = 0; j < (1 << k); j++) begin
        codes[(1 << k) + j] = codes[(1 << k) - 1 - j] | W'(1 << k);
      end
    end

    #1;
    check("rst_async.gray", {{(32-W){1'b0}}, gray}, 32'h0);
    check("rst_async.valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release.gray", {{(32-W){1'b0}}, gray}, 32'h0);
    check("rst_release.valid", {31'b0, out_valid}, 32'h0);

    // directed sequence with hand-written expectations
    step(1'b1, 4'b0000, "dir0"); check("dir0.const", {28'b0, gray}, 32'h0);
    step(1'b1, 4'b0001, "dir1"); check("dir1.const", {28'b0, gray}, 32'h1);
    step(1'b1, 4'b0010, "dir2"); check("dir2.const", {28'b0, gray}, 32'h3);
    step(1'b1, 4'b0011, "dir3"); check("dir3.const", {28'b0, gray}, 32'h2);
    step(1'b1, 4'b0100, "dir4"); check("dir4.const", {28'b0, gray}, 32'h6);
    step(1'b1, 4'b1111, "dir5"); check("dir5.const", {28'b0, gray}, 32'h8);

    // full sweep with wrap, adjacent codes differ in exactly one bit
    step(1'b1, '0, "sweep");
    prev_gray = gray;
    for (int i = 1; i <= int'(N); i++) begin
      step(1'b1, W'(i % N), "sweep");
      check("sweep.hamming", $countones(prev_gray ^ gray), 32'd1);
      prev_gray = gray;
    end
    check("wrap.zero", {28'b0, gray}, 32'h0);

    // hold while idle
    step(1'b1, 4'b0101, "hold_load"); check("hold_load.const", {28'b0, gray}, 32'h7);
    step(1'b0, 4'b1010, "hold");      check("hold.const", {28'b0, gray}, 32'h7);
    step(1'b0, 4'b0011, "hold2");

    // reset between edges while a word is presented
    step(1'b1, 4'b1001, "pre_rst");
    step(1'b1, 4'b1010, "pre_rst");
    #2;
    binary = 4'b1100;
    rst    = 1'b1;
    #1;
    check("mid_rst.gray", {28'b0, gray}, 32'h0);
    check("mid_rst.valid", {31'b0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_drop.gray", {28'b0, gray}, 32'h0);
    check("rst_drop.valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    exp_gray = '0;
    exp_valid = 1'b0;
    step(1'b1, 4'b0110, "post_rst"); check("post_rst.const", {28'b0, gray}, 32'h5);

    // randomized traffic, mostly valid
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), W'($urandom), "rand");
    end

`ifdef BIN2GRAY_SELFCHECK_EN
    check("selfcheck.clean", {31'b0, check_err}, 32'h0);
    step(1'b1, 4'b0101, "sc_load");
    @(negedge clk);
    in_valid = 1'b0;
    force dut.gray = 4'b0110;
    @(posedge clk);
    #1;
    release dut.gray;
    check("selfcheck.flag", {31'b0, check_err}, 32'h1);
    step(1'b1, 4'b0011, "sc_sticky");
    check("selfcheck.sticky", {31'b0, check_err}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("selfcheck.rst", {31'b0, check_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
